// File: rtl/fsb_pkg.sv
// Shared definitions for the epRISC front-side-bus arbiter: FSM states,
// address-region boundaries and master indices.
package fsb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2,
      TURN = 2'd3
   } fsbState_t;

   // Lower bound of each region; every region ends where the next begins.
   localparam logic [31:0] RAM_BASE      = 32'h0000_1000;
   localparam logic [31:0] BUS_CTRL_BASE = 32'h0000_2000;
   localparam logic [31:0] SDRAM_BASE    = 32'h0000_3000;
   localparam logic [31:0] EXTRA_BASE    = 32'h0080_0000;

   localparam int MASTER_CORE = 0;
   localparam int MASTER_DMA  = 1;

endpackage

// File: rtl/fsb_region_decode.sv
// Combinational FSB address decode into one-hot slave selects.
// All selects are low while no access is in progress.
module fsb_region_decode
   import fsb_pkg::*;
(
   input  logic [31:0] iAddress,
   input  logic        iAccess,
   output logic        oEnableROM,
   output logic        oEnableRAM,
   output logic        oEnableBusControl,
   output logic        oEnableSDRAM,
   output logic        oDisableExtra
);

   // Priority compare on ascending bounds yields exactly one select per access.
   always_comb begin
      oEnableROM        = 1'b0;
      oEnableRAM        = 1'b0;
      oEnableBusControl = 1'b0;
      oEnableSDRAM      = 1'b0;
      oDisableExtra     = 1'b0;
      if (iAccess) begin
         if (iAddress < RAM_BASE)           oEnableROM        = 1'b1;
         else if (iAddress < BUS_CTRL_BASE) oEnableRAM        = 1'b1;
         else if (iAddress < SDRAM_BASE)    oEnableBusControl = 1'b1;
         else if (iAddress < EXTRA_BASE)    oEnableSDRAM      = 1'b1;
         else                               oDisableExtra     = 1'b1;
      end
   end

endmodule

// File: rtl/fsb_arbiter.sv
// Round-robin two-master FSB arbiter with a one-cycle turnaround between
// owners, address/control mux, region selects and per-master ready.
// Optional stall watchdog enabled by defining FSB_TIMEOUT_EN.
module fsb_arbiter
   import fsb_pkg::*;
#(
   parameter int unsigned pTimeout = 255
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [1:0]  iRequest,
   input  logic        iAccess0,
   input  logic        iAccess1,
   input  logic [31:0] iAddress0,
   input  logic [31:0] iAddress1,
   input  logic        iWrite0,
   input  logic        iWrite1,
   input  logic        iReady,
   output logic [1:0]  oGrant,
   output logic [31:0] oAddress,
   output logic        oWrite,
   output logic        oAccess,
   output logic [1:0]  oReady,
   output logic        oEnableROM,
   output logic        oEnableRAM,
   output logic        oEnableBusControl,
   output logic        oEnableSDRAM,
   output logic        oDisableExtra,
   output logic        oTimeout
);

   fsbState_t  rState, wNextState;
   logic       rLast, wNextLast;
   logic [1:0] rGrant, wNextGrant;

   // State, round-robin history and grant register.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         rState <= IDLE;
         rLast  <= 1'b1;
         rGrant <= 2'b00;
      end else begin
         rState <= wNextState;
         rLast  <= wNextLast;
         rGrant <= wNextGrant;
      end
   end

   // Next-state arbitration; TURN re-arbitrates in the same edge it leaves.
   always_comb begin
      wNextState = rState;
      wNextLast  = rLast;
      wNextGrant = 2'b00;
      case (rState)
         IDLE, TURN: begin
            wNextState = IDLE;
            if (iRequest[MASTER_CORE] && iRequest[MASTER_DMA])
               wNextState = rLast ? OWN0 : OWN1;
            else if (iRequest[MASTER_CORE])
               wNextState = OWN0;
            else if (iRequest[MASTER_DMA])
               wNextState = OWN1;
         end
         OWN0: begin
            if (!iRequest[MASTER_CORE]) begin
               wNextState = TURN;
               wNextLast  = 1'b0;
            end
         end
         OWN1: begin
            if (!iRequest[MASTER_DMA]) begin
               wNextState = TURN;
               wNextLast  = 1'b1;
            end
         end
         default: wNextState = IDLE;
      endcase
      if (wNextState == OWN0) wNextGrant[MASTER_CORE] = 1'b1;
      if (wNextState == OWN1) wNextGrant[MASTER_DMA]  = 1'b1;
   end

   assign oGrant = rGrant;

   // Bus mux follows the registered grant; idle bus reads as all zeros.
   always_comb begin
      oAddress = 32'h0;
      oWrite   = 1'b0;
      oAccess  = 1'b0;
      if (rGrant[MASTER_CORE]) begin
         oAddress = iAddress0;
         oWrite   = iWrite0;
         oAccess  = iAccess0;
      end else if (rGrant[MASTER_DMA]) begin
         oAddress = iAddress1;
         oWrite   = iWrite1;
         oAccess  = iAccess1;
      end
   end

   assign oReady = rGrant & {2{iReady | oTimeout}};

   fsb_region_decode uDecode (
      .iAddress          (oAddress),
      .iAccess           (oAccess),
      .oEnableROM        (oEnableROM),
      .oEnableRAM        (oEnableRAM),
      .oEnableBusControl (oEnableBusControl),
      .oEnableSDRAM      (oEnableSDRAM),
      .oDisableExtra     (oDisableExtra)
   );

`ifdef FSB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(pTimeout - 1);

   logic [15:0] rStallCount;
   logic [1:0]  rGrantPrev;
   logic        wStall;

   assign wStall   = oAccess & ~iReady;
   assign oTimeout = wStall & (rStallCount == TIMEOUT_LAST);

   // Stall counter: clears on ready, owner change or abort; saturates at max.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         rStallCount <= 16'h0;
         rGrantPrev  <= 2'b00;
      end else begin
         rGrantPrev <= rGrant;
         if (iReady || (rGrant != rGrantPrev) || oTimeout)
            rStallCount <= 16'h0;
         else if (wStall && (rStallCount != 16'hFFFF))
            rStallCount <= rStallCount + 16'h1;
      end
   end
`else
   assign oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_fsb_arbiter.sv
// Scoreboard bench for fsb_arbiter: stimulus pushes expected bus snapshots,
// an independent monitor pops and compares one snapshot per cycle.
module tb_fsb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic        acc0, acc1, w0, w1, rdyIn;
   logic [31:0] addr0, addr1;

   logic [1:0]  oGrant, oReady;
   logic [31:0] oAddress;
   logic        oWrite, oAccess, oTimeout;
   logic        eRom, eRam, eBc, eSd, eEx;

   localparam logic [4:0] EN_NONE = 5'b00000;
   localparam logic [4:0] EN_ROM  = 5'b10000;
   localparam logic [4:0] EN_RAM  = 5'b01000;
   localparam logic [4:0] EN_BC   = 5'b00100;
   localparam logic [4:0] EN_SD   = 5'b00010;
   localparam logic [4:0] EN_EX   = 5'b00001;

   typedef struct {
      string      nm;
      logic [43:0] v;
   } exp_t;

   exp_t sb[$];
   exp_t monItem;
   int   errors = 0;
   int   checks = 0;
   logic [43:0] obs;

   always #5 clk = ~clk;

   fsb_arbiter #(.pTimeout(8)) dut (
      .iClock            (clk),
      .iReset            (rst),
      .iRequest          (req),
      .iAccess0          (acc0),
      .iAccess1          (acc1),
      .iAddress0         (addr0),
      .iAddress1         (addr1),
      .iWrite0           (w0),
      .iWrite1           (w1),
      .iReady            (rdyIn),
      .oGrant            (oGrant),
      .oAddress          (oAddress),
      .oWrite            (oWrite),
      .oAccess           (oAccess),
      .oReady            (oReady),
      .oEnableROM        (eRom),
      .oEnableRAM        (eRam),
      .oEnableBusControl (eBc),
      .oEnableSDRAM      (eSd),
      .oDisableExtra     (eEx),
      .oTimeout          (oTimeout)
   );

   assign obs = {oGrant, oAddress, oWrite, oAccess, oReady,
                 eRom, eRam, eBc, eSd, eEx, oTimeout};

   function automatic string fmt(input logic [43:0] v);
      return $sformatf("g=%b a=%h w=%b acc=%b rdy=%b en=%b to=%b",
                       v[43:42], v[41:10], v[9], v[8], v[7:6], v[5:1], v[0]);
   endfunction

   // Monitor: one comparison per cycle whenever an expectation is pending.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            monItem = sb.pop_front();
            checks++;
            if (obs !== monItem.v) begin
               errors++;
               $display("FAIL %s: got %s, required %s",
                        monItem.nm, fmt(obs), fmt(monItem.v));
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [1:0] g, input logic [31:0] a,
                      input logic w, input logic ac, input logic [1:0] rd,
                      input logic [4:0] en, input logic to);
      exp_t e;
      @(posedge clk);
      e.nm = nm;
      e.v  = {g, a, w, ac, rd, en, to};
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic chkIdle(input string nm);
      chk(nm, 2'b00, 32'h0, 1'b0, 1'b0, 2'b00, EN_NONE, 1'b0);
   endtask

   logic [31:0] sweepAddr [5];
   logic [4:0]  sweepEn   [5];

   initial begin
      sweepAddr[0] = 32'h0000_1000; sweepEn[0] = EN_RAM;
      sweepAddr[1] = 32'h0000_2FFF; sweepEn[1] = EN_BC;
      sweepAddr[2] = 32'h0000_3000; sweepEn[2] = EN_SD;
      sweepAddr[3] = 32'h007F_FFFF; sweepEn[3] = EN_SD;
      sweepAddr[4] = 32'h0080_0000; sweepEn[4] = EN_EX;

      rst = 1'b1; req = 2'b00; acc0 = 1'b0; acc1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
      addr0 = 32'h0; addr1 = 32'h0; rdyIn = 1'b1;
      chkIdle("reset");

      // Single core request
      rst = 1'b0; req = 2'b01; acc0 = 1'b1; addr0 = 32'h0000_1004;
      chk("grant_core", 2'b01, 32'h1004, 1'b0, 1'b1, 2'b01, EN_RAM, 1'b0);
      req = 2'b00; acc0 = 1'b0;
      chkIdle("turn_after_core");
      chkIdle("idle_after_turn");

      // Ties and round-robin
      rst = 1'b1;
      chkIdle("reset2");
      rst = 1'b0; req = 2'b11;
      acc0 = 1'b1; addr0 = 32'h0000_0010; w0 = 1'b0;
      acc1 = 1'b1; addr1 = 32'h0050_0000; w1 = 1'b1;
      chk("tie_core_first", 2'b01, 32'h10, 1'b0, 1'b1, 2'b01, EN_ROM, 1'b0);
      req = 2'b10;
      chkIdle("turn_core_release");
      req = 2'b11;
      chk("tie_dma_after_core", 2'b10, 32'h50_0000, 1'b1, 1'b1, 2'b10, EN_SD, 1'b0);
      chk("no_preempt", 2'b10, 32'h50_0000, 1'b1, 1'b1, 2'b10, EN_SD, 1'b0);
      req = 2'b01;
      chkIdle("turn_dma_release");
      req = 2'b11;
      chk("tie_core_after_dma", 2'b01, 32'h10, 1'b0, 1'b1, 2'b01, EN_ROM, 1'b0);
      req = 2'b00;
      chkIdle("turn2");
      chkIdle("idle2");

      // Address sweep under core ownership
      req = 2'b01; acc1 = 1'b0; w1 = 1'b0; acc0 = 1'b1; addr0 = 32'h0000_0FFF;
      chk("sweep_0fff", 2'b01, 32'h0FFF, 1'b0, 1'b1, 2'b01, EN_ROM, 1'b0);
      for (int i = 0; i < 5; i++) begin
         addr0 = sweepAddr[i];
         chk($sformatf("sweep_%h", sweepAddr[i]), 2'b01, sweepAddr[i],
             1'b0, 1'b1, 2'b01, sweepEn[i], 1'b0);
      end
      acc0 = 1'b0;
      chk("no_access", 2'b01, 32'h0080_0000, 1'b0, 1'b0, 2'b01, EN_NONE, 1'b0);
      acc0 = 1'b1; w0 = 1'b1; addr0 = 32'h0000_1800;
      chk("write_ram", 2'b01, 32'h1800, 1'b1, 1'b1, 2'b01, EN_RAM, 1'b0);

      // Stalled SDRAM read
      w0 = 1'b0; addr0 = 32'h0000_3000; rdyIn = 1'b0;
`ifdef FSB_TIMEOUT_EN
      for (int k = 1; k <= 9; k++) begin
         chk($sformatf("stall_%0d", k), 2'b01, 32'h3000, 1'b0, 1'b1,
             (k == 7) ? 2'b01 : 2'b00, EN_SD, (k == 7));
      end
`else
      for (int k = 1; k <= 100; k++) begin
         chk($sformatf("stall_%0d", k), 2'b01, 32'h3000, 1'b0, 1'b1,
             2'b00, EN_SD, 1'b0);
      end
`endif
      rdyIn = 1'b1;
      chk("ready_back", 2'b01, 32'h3000, 1'b0, 1'b1, 2'b01, EN_SD, 1'b0);
      req = 2'b00; acc0 = 1'b0;
      chkIdle("turn3");
      chkIdle("idle3");

      // Reset during a DMA access with the core waiting
      req = 2'b10; acc1 = 1'b1; addr1 = 32'h0000_2000;
      chk("dma_own", 2'b10, 32'h2000, 1'b0, 1'b1, 2'b10, EN_BC, 1'b0);
      req = 2'b11; acc0 = 1'b1; addr0 = 32'h0000_1004;
      chk("dma_hold", 2'b10, 32'h2000, 1'b0, 1'b1, 2'b10, EN_BC, 1'b0);
      rst = 1'b1;
      chkIdle("reset_mid_access");
      rst = 1'b0;
      chk("core_after_reset", 2'b01, 32'h1004, 1'b0, 1'b1, 2'b01, EN_RAM, 1'b0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: pending=%0d, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
